// File: rtl/muu_pkg.sv
// Shared definitions for the muu take-protocol framer.
//   state_t          : framer FSM states (WAIT_META, HEAD, BODY)
//   tag_t            : per-word tag carried through the skid buffer (head/cont)
//   TAKE_SIZE_EXEMPT : take_size value marking a packet exempt from token accounting
//   encode_size()    : maps a metadata beat to the take_size presented with the head word
package muu_pkg;

  typedef enum logic [1:0] {
    WAIT_META,
    HEAD,
    BODY
  } state_t;

  typedef enum logic {
    TAG_HEAD = 1'b0,
    TAG_CONT = 1'b1
  } tag_t;

  localparam logic [15:0] TAKE_SIZE_EXEMPT = 16'hFFFF;

  // A real length of 16'hFFFF would alias the exempt marker, so it is clipped by one.
  function automatic logic [15:0] encode_size(input logic [15:0] len, input logic exempt);
    if (exempt) return TAKE_SIZE_EXEMPT;
    if (len == TAKE_SIZE_EXEMPT) return TAKE_SIZE_EXEMPT - 16'd1;
    return len;
  endfunction

endpackage

// File: rtl/muu_skid_buf.sv
// 2-entry valid/ready register slice carrying {tag, size, data}.
// Outputs come straight from the output register; the second (skid) entry
// catches the word accepted in the cycle the consumer stalls, so s_ready is
// itself a register and throughput stays at one word per cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   s_valid/s_ready     : upstream handshake, s_tag/s_size/s_data payload
//   m_valid/m_ready     : downstream handshake, m_tag/m_size/m_data payload
module muu_skid_buf #(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_tag,
  input  logic [15:0]           s_size,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_tag,
  output logic [15:0]           m_size,
  output logic [DATA_WIDTH-1:0] m_data
);

  logic                  skid_valid;
  logic                  skid_tag;
  logic [15:0]           skid_size;
  logic [DATA_WIDTH-1:0] skid_data;

  assign s_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_tag      <= 1'b0;
      m_size     <= '0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_tag   <= 1'b0;
      skid_size  <= '0;
      skid_data  <= '0;
    end else if (m_ready || !m_valid) begin
      // Output slot frees up: refill from skid first to keep ordering.
      if (skid_valid) begin
        m_valid    <= 1'b1;
        m_tag      <= skid_tag;
        m_size     <= skid_size;
        m_data     <= skid_data;
        skid_valid <= 1'b0;
      end else if (s_valid) begin
        m_valid <= 1'b1;
        m_tag   <= s_tag;
        m_size  <= s_size;
        m_data  <= s_data;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (s_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_tag   <= s_tag;
      skid_size  <= s_size;
      skid_data  <= s_data;
    end
  end

endmodule

// File: rtl/muu_take_framer.sv
// Pairs a per-packet metadata beat with the packet's data words and emits them
// in the shaper's take protocol: head word on take_valid with take_size,
// following words on take_cont, last word flagged in take_data[DATA_WIDTH-1].
// Optional feature macro: MUU_FRAMER_LENCHECK_EN (per-packet word-count check
// against ceil(meta_len/WORD_BYTES); drives len_err / err_count).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   meta_valid/meta_ready            : metadata handshake (meta_len, meta_exempt)
//   in_valid/in_ready                : data word handshake (in_data, in_last)
//   take_valid/take_cont/take_ready  : head / continuation word handshake
//   take_size, take_data             : head packet size, {last, payload}
//   len_err, err_count               : length-mismatch pulse and saturating count
module muu_take_framer
  import muu_pkg::*;
#(
  parameter int          DATA_WIDTH = 256,
  parameter int unsigned WORD_BYTES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  meta_valid,
  input  logic [15:0]           meta_len,
  input  logic                  meta_exempt,
  output logic                  meta_ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-2:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  take_valid,
  output logic                  take_cont,
  output logic [15:0]           take_size,
  output logic [DATA_WIDTH-1:0] take_data,
  input  logic                  take_ready,
  output logic                  len_err,
  output logic [15:0]           err_count
);

  if (WORD_BYTES == 0 || DATA_WIDTH < 2) begin : g_bad_params
    $error("muu_take_framer: WORD_BYTES must be nonzero and DATA_WIDTH at least 2");
  end

  state_t      state, state_nxt;
  logic [15:0] len_q;
  logic        exempt_q;
  logic        in_pkt;
  logic        buf_ready;
  logic        word_ok;
  logic        meta_hs;
  tag_t        word_tag;
  logic        out_valid;
  logic        out_tag;

  assign in_pkt   = (state != WAIT_META);
  assign in_ready = buf_ready && in_pkt;
  assign word_ok  = in_valid && in_ready;
  assign meta_hs  = meta_valid && meta_ready;
  assign word_tag = (state == HEAD) ? TAG_HEAD : TAG_CONT;

  // Inside a packet the next meta is only taken alongside the last word,
  // letting the following packet start with no idle cycle.
  always_comb begin
    meta_ready = 1'b1;
    state_nxt  = state;
    case (state)
      WAIT_META: begin
        if (meta_hs) state_nxt = HEAD;
      end
      HEAD, BODY: begin
        meta_ready = word_ok && in_last;
        if (word_ok) begin
          if (in_last)            state_nxt = meta_hs ? HEAD : WAIT_META;
          else if (state == HEAD) state_nxt = BODY;
        end
      end
      default: state_nxt = WAIT_META;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_META;
      len_q    <= '0;
      exempt_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (meta_hs) begin
        len_q    <= meta_len;
        exempt_q <= meta_exempt;
      end
    end
  end

  muu_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .s_valid(in_valid && in_pkt),
    .s_ready(buf_ready),
    .s_tag  (word_tag),
    .s_size (encode_size(len_q, exempt_q)),
    .s_data ({in_last, in_data}),
    .m_valid(out_valid),
    .m_ready(take_ready),
    .m_tag  (out_tag),
    .m_size (take_size),
    .m_data (take_data)
  );

  assign take_valid = out_valid && (out_tag == TAG_HEAD);
  assign take_cont  = out_valid && (out_tag == TAG_CONT);

`ifdef MUU_FRAMER_LENCHECK_EN
  logic [11:0] word_cnt;
  logic [16:0] exp_words;
  logic [16:0] got_words;

  assign exp_words = 17'((32'(len_q) + WORD_BYTES - 32'd1) / WORD_BYTES);
  assign got_words = {5'd0, word_cnt} + 17'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= '0;
      len_err   <= 1'b0;
      err_count <= '0;
    end else begin
      len_err <= 1'b0;
      if (word_ok) begin
        if (in_last) begin
          word_cnt <= '0;
          if (!exempt_q && (got_words != exp_words)) begin
            len_err <= 1'b1;
            if (err_count != '1) err_count <= err_count + 16'd1;
          end
        end else begin
          word_cnt <= word_cnt + 12'd1;
        end
      end
    end
  end
`else
  assign len_err   = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: doc/muu_take_framer.md
# muu_take_framer

Upstream feeder for the token-bucket shaper in the muu datapath. Pairs a per-packet metadata beat (byte length, exempt flag) with the packet's data words. Emits them in the shaper's take protocol:
- first word on `take_valid` with `take_size`;
- following words on `take_cont`;
- the last word marked by `take_data[DATA_WIDTH-1]`.

A 2-entry skid buffer gives full throughput with registered outputs.

## Interface
Parameters:
- DATA_WIDTH, 256, width of `take_data`; the MSB is the last-word flag.
- WORD_BYTES, 32, payload bytes per word, used by the length check.

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- meta_valid  in  1  metadata beat valid
- meta_len  in  16  packet length in bytes
- meta_exempt  in  1  packet bypasses token accounting
- meta_ready  out  1  metadata accepted when valid&ready
- in_valid  in  1  data word valid
- in_data  in  DATA_WIDTH-1  payload word
- in_last  in  1  last word of packet
- in_ready  out  1  data word accepted when valid&ready
- take_valid  out  1  head word of packet presented
- take_cont  out  1  continuation word presented
- take_size  out  16  byte length of the head word's packet
- take_data  out  DATA_WIDTH  {last flag, payload}
- take_ready  in  1  downstream accepts the presented word
- len_err  out  1  one-cycle pulse on length mismatch
- err_count  out  16  saturating mismatch counter

## Operation
FSM states:
- **WAIT_META**
  - `meta_ready`=1 and `in_ready`=0.
  - On a meta handshake: latch the length and exempt flag; go to HEAD.
- **HEAD**
  - The next accepted word is tagged head.
  - If it has `in_last`, return to WAIT_META; otherwise go to BODY.
- **BODY**
  - Accepted words are tagged cont.
  - On an accepted word with `in_last`, return to WAIT_META.
- **Back-to-back packets:** in HEAD or BODY, `meta_ready` = `in_valid & in_ready & in_last`. The next meta is taken in the same cycle as the last word, goes straight to HEAD, and leaves no bubble.

Size encoding:
- Exempt packet: `take_size` = 16'hFFFF.
- Otherwise `take_size` = `meta_len`. A `meta_len` of 16'hFFFF is saturated to 16'hFFFE so it is never read as exempt.
- `take_size` is valid only with `take_valid`; it holds the value of the head word currently presented.

Word tagging:
- A head word drives `take_valid`=1, `take_cont`=0.
- A continuation word drives `take_valid`=0, `take_cont`=1.
- The two are never both 1.
- `take_data[DATA_WIDTH-1]` = `in_last`; `take_data[DATA_WIDTH-2:0]` = `in_data`.

Output handshake:
- A presented word, with its tag, size and data, holds stable until `take_ready`=1. The shaper samples `take_valid`/`take_size` while frozen, so stability is mandatory.
- `in_ready` = skid buffer not full and state ≠ WAIT_META.

## Timing
- Latency: one cycle from input handshake to presentation on `take_*`, when the skid buffer is empty.
- Throughput: one word per cycle with `take_ready` held at 1.
- `take_ready` low: the skid buffer absorbs one word, then `in_ready` drops the following cycle.
- Reset values:
  - `take_valid`=0, `take_cont`=0, `take_size`=0, `take_data`=0;
  - `len_err`=0, `err_count`=0;
  - FSM in WAIT_META, skid buffer empty, so `meta_ready`=1 and `in_ready`=0.
- Reset mid-packet discards the buffered words and the partial packet. Upstream must also restart.
- `in_valid` during WAIT_META is not accepted; the word waits for its meta.

## Configuration
Macro `MUU_FRAMER_LENCHECK_EN`:
- **Defined:**
  - A 12-bit word counter runs per packet.
  - On the last word, the count is compared with ceil(`meta_len`/WORD_BYTES). Exempt packets are not checked.
  - On mismatch, `len_err` pulses for 1 cycle and `err_count` increments, saturating at 16'hFFFF.
  - Framing always follows `in_last`.
- **Undefined:** no counter logic; `len_err` is tied 0 and `err_count` is tied 0.

## Structure
- Shared package `muu_pkg`:
  - FSM state enum (WAIT_META, HEAD, BODY);
  - the TAKE_SIZE_EXEMPT = 16'hFFFF constant;
  - a tag typedef {head, cont}.
- Sub-module: `muu_skid_buf`, a 2-entry valid/ready register slice carrying {tag, size, data}.

## Test plan
- Single-word packet: meta_len=20 plus one word with `in_last` → `take_valid`=1, `take_size`=20, MSB=1, `take_cont` never asserted.
- Three-word packet, meta_len=90, `take_ready`=1 → head word with `take_size`=90, then two `take_cont` words, third with MSB=1; words on consecutive cycles.
- Exempt packet with meta_len=500 → `take_size`=16'hFFFF. A non-exempt packet with meta_len=16'hFFFF → `take_size`=16'hFFFE.
- Backpressure: `take_ready` low for 5 cycles mid-packet → outputs stable throughout, `in_ready` low after one buffered word, no loss or duplication.
- Back-to-back packets, next meta valid at the last word → next head word presented on the very next output cycle.
- With `MUU_FRAMER_LENCHECK_EN` defined: meta_len=64, WORD_BYTES=32, three words sent → `len_err` pulses once, `err_count`=1, all three words still forwarded.
